// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Optional performance counters are enabled by defining PIPE_SKID_PERF_EN.
module pipe_stage_skid #(
  parameter int DATA_W      = 128,
  parameter int PC_W        = 32,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  input  logic              flush,
  input  logic              irq,
  output logic [1:0]        occupancy
`ifdef PIPE_SKID_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_main_data;
  logic [DATA_W-1:0] r_skid_data;
  logic [PC_W-1:0]   r_main_pc;
  logic [PC_W-1:0]   r_skid_pc;

  logic              w_accept;
  logic              w_drain;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid;
  logic              w_out_valid;

  assign w_out_valid = (r_state != EMPTY);
  assign w_accept    = in_valid & r_in_ready;
  assign w_drain     = w_out_valid & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (irq || flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_nxt    = ONE;
            w_load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (w_accept && w_drain) begin
            w_load_main_in = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = TWO;
            w_load_skid = 1'b1;
          end else if (w_drain) begin
            w_state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (w_drain) begin
            w_state_nxt      = ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // Control registers; ready is precomputed from the next state so it never depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_data <= '0;
    end else if (w_load_main_in) begin
      r_main_data <= in_data;
    end else if (w_load_main_skid) begin
      r_main_data <= r_skid_data;
    end
  end

  // PC survives flush so the exception unit can still read it; only irq and reset clear it.
  always_ff @(posedge clk) begin
    if (reset || irq) begin
      r_main_pc <= '0;
    end else if (w_load_main_in) begin
      r_main_pc <= in_pc;
    end else if (w_load_main_skid) begin
      r_main_pc <= r_skid_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (w_load_skid) begin
      r_skid_data <= in_data;
      r_skid_pc   <= in_pc;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = (ZERO_BUBBLE && !w_out_valid) ? '0 : r_main_data;
  assign out_pc    = r_main_pc;
  assign occupancy = r_state;

`ifdef PIPE_SKID_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (in_valid && !r_in_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (out_ready && !w_out_valid) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
